// File: rtl/pe_traffic_node_if.sv
// NoC port bundle between a PE traffic node and its router port.
// master = PE side (injects on o_data, sinks i_data).
interface pe_traffic_node_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic [DATA_W+ADDR_W-1:0] o_data;
    logic                     o_data_valid;
    logic                     i_data_ready;
    logic [DATA_W+ADDR_W-1:0] i_data;
    logic                     i_data_valid;
    logic                     o_data_ready;

    modport master (
        output o_data, o_data_valid, o_data_ready,
        input  i_data_ready, i_data, i_data_valid
    );

    modport slave (
        input  o_data, o_data_valid, o_data_ready,
        output i_data_ready, i_data, i_data_valid
    );
endinterface

// File: rtl/pe_traffic_node.sv
// Synthetic PE endpoint: injects PKT_LIMIT LFSR-addressed packets and
// sinks delivered ones, counting both and flagging misrouted arrivals.
module pe_traffic_node #(
    parameter int          ADDRESS   = 0,
    parameter int          NUMPE     = 8,
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = $clog2(NUMPE),
    parameter int          PKT_LIMIT = 100,
    parameter int          GAP       = 0,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    pe_traffic_node_if.master  noc,
    input  logic               done,
    output logic [15:0]        o_sent_cnt,
    output logic [15:0]        o_rcvd_cnt,
    output logic               o_err,
    output logic               o_tx_done
);
    localparam int              PKT_W   = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(ADDRESS);
    localparam logic [15:0]     LIMIT   = 16'(PKT_LIMIT);
    localparam logic [15:0]     GAP_M1  = 16'(GAP > 0 ? GAP - 1 : 0);
    localparam logic [15:0]     LFSR_RST = SEED ^ 16'(ADDRESS);

    typedef enum logic [2:0] {
        IDLE, LOAD, SEND, WAIT, FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [15:0]        sent_q, sent_d;
    logic [15:0]        rcvd_q, rcvd_d;
    logic [15:0]        gap_q, gap_d;
    logic [PKT_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               rdy_q;
    logic               err_q, err_d;

    logic               hs;
    logic               rx_hit;
    logic [15:0]        lfsr_nxt;
    logic [15:0]        sent_inc;

    // Self-addressed destinations are bumped to the next port so every
    // injected packet really crosses the NoC.
    function automatic logic [PKT_W-1:0] build(
        input logic [15:0] lf,
        input logic [15:0] seq
    );
        logic [ADDR_W-1:0] d;
        logic [DATA_W-1:0] p;
        d = lf[ADDR_W-1:0];
        if (d == MY_ADDR) d = d + ADDR_W'(1);
        p = '0;
        p[DATA_W-1 -: ADDR_W] = MY_ADDR;
        p[15:0] = seq;
        return {d, p};
    endfunction

    assign hs       = valid_q && noc.i_data_ready;
    assign rx_hit   = noc.i_data_valid && rdy_q;
    assign lfsr_nxt = {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign sent_inc = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_RST;
            sent_q  <= '0;
            rcvd_q  <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sent_q  <= sent_d;
            rcvd_q  <= rcvd_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rdy_q   <= 1'b1;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = done ? FINISH : LOAD;
            LOAD:   state_d = done ? FINISH : SEND;
            SEND: begin
                if (hs) begin
                    if (done || sent_inc == LIMIT) state_d = FINISH;
                    else if (GAP == 0)             state_d = SEND;
                    else                           state_d = WAIT;
                end else if (done) begin
                    state_d = FINISH;
                end
            end
            WAIT: begin
                if (done)            state_d = FINISH;
                else if (gap_q == 0) state_d = SEND;
            end
            FINISH: state_d = FINISH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (state_q == SEND && hs) begin
            lfsr_d = lfsr_nxt;
            sent_d = sent_inc;
            gap_d  = GAP_M1;
        end
        if (state_q == WAIT && gap_q != 0) gap_d = gap_q - 16'd1;
        // A stalled packet keeps its bits; only a fresh entry or a
        // completed handshake loads the next one.
        if (state_d == SEND) begin
            valid_d = 1'b1;
            if (state_q != SEND || hs) data_d = build(lfsr_d, sent_d);
        end
    end

    always_comb begin
        rcvd_d = rcvd_q;
        err_d  = err_q;
        if (rx_hit) begin
            if (rcvd_q != 16'hFFFF) rcvd_d = rcvd_q + 16'd1;
            if (noc.i_data[PKT_W-1 -: ADDR_W] != MY_ADDR) err_d = 1'b1;
        end
    end

    assign noc.o_data       = data_q;
    assign noc.o_data_valid = valid_q;
    assign noc.o_data_ready = rdy_q;
    assign o_sent_cnt       = sent_q;
    assign o_rcvd_cnt       = rcvd_q;
    assign o_err            = err_q;
    assign o_tx_done        = (state_q == FINISH);
endmodule

// File: tb/tb_pe_traffic_node.sv
// Directed bench for pe_traffic_node: a GAP=0 node at address 3 and a
// GAP=2 node at address 5, PKT_LIMIT 100 and 10.
module tb_pe_traffic_node;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_traffic_node_if #(.DATA_W(32), .ADDR_W(3)) bus_a ();
    pe_traffic_node_if #(.DATA_W(32), .ADDR_W(3)) bus_b ();

    logic        done_a, done_b;
    logic [15:0] sent_a, rcvd_a, sent_b, rcvd_b;
    logic        err_a, err_b, txd_a, txd_b;

    int tests = 0;
    int fails = 0;

    pe_traffic_node #(
        .ADDRESS(3), .NUMPE(8), .DATA_W(32), .ADDR_W(3),
        .PKT_LIMIT(100), .GAP(0), .SEED(16'hACE1)
    ) dut_a (
        .clk(clk), .rst(rst), .noc(bus_a), .done(done_a),
        .o_sent_cnt(sent_a), .o_rcvd_cnt(rcvd_a),
        .o_err(err_a), .o_tx_done(txd_a)
    );

    pe_traffic_node #(
        .ADDRESS(5), .NUMPE(8), .DATA_W(32), .ADDR_W(3),
        .PKT_LIMIT(10), .GAP(2), .SEED(16'hACE1)
    ) dut_b (
        .clk(clk), .rst(rst), .noc(bus_b), .done(done_b),
        .o_sent_cnt(sent_b), .o_rcvd_cnt(rcvd_b),
        .o_err(err_b), .o_tx_done(txd_b)
    );

    function automatic logic [34:0] pkt(
        input logic [2:0]  d,
        input logic [2:0]  src,
        input logic [15:0] seq
    );
        return {d, src, 13'd0, seq};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bus_a.i_data_ready = 1'b0;
        rst = 1'b1;
        tick;
        tests++;
        if (bus_a.o_data_valid !== 1'b0 || bus_a.o_data !== 35'd0 ||
            bus_a.o_data_ready !== 1'b0 || sent_a !== 16'd0 ||
            rcvd_a !== 16'd0 || err_a !== 1'b0 || txd_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_a: v=%b d=%h r=%b s=%0d c=%0d e=%b t=%b",
                     bus_a.o_data_valid, bus_a.o_data, bus_a.o_data_ready,
                     sent_a, rcvd_a, err_a, txd_a);
        end
        tests++;
        if (bus_b.o_data_valid !== 1'b0 || sent_b !== 16'd0 ||
            txd_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_b: v=%b s=%0d t=%b, want 0 0 0",
                     bus_b.o_data_valid, sent_b, txd_b);
        end
        rst = 1'b0;
        tick;
        tests++;
        if (bus_a.o_data_valid !== 1'b0 || bus_a.o_data_ready !== 1'b1) begin
            fails++;
            $display("FAIL edge1: valid=%b ready=%b, want 0 1",
                     bus_a.o_data_valid, bus_a.o_data_ready);
        end
        tick;
        tests++;
        if (bus_a.o_data_valid !== 1'b1 || bus_a.o_data !== pkt(3'd2, 3'd3, 16'd0)) begin
            fails++;
            $display("FAIL first_pkt: valid=%b data=%h, want 1 %h",
                     bus_a.o_data_valid, bus_a.o_data, pkt(3'd2, 3'd3, 16'd0));
        end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 5; i++) begin
            tick;
            tests++;
            if (bus_a.o_data_valid !== 1'b1 || sent_a !== 16'd0 ||
                bus_a.o_data !== pkt(3'd2, 3'd3, 16'd0)) begin
                fails++;
                $display("FAIL bp_hold[%0d]: v=%b d=%h s=%0d, want 1 %h 0", i,
                         bus_a.o_data_valid, bus_a.o_data, sent_a,
                         pkt(3'd2, 3'd3, 16'd0));
            end
        end
        bus_a.i_data_ready = 1'b1;
        tick;
        bus_a.i_data_ready = 1'b0;
        tests++;
        if (sent_a !== 16'd1 || bus_a.o_data !== pkt(3'd5, 3'd3, 16'd1)) begin
            fails++;
            $display("FAIL bp_accept: s=%0d d=%h, want 1 %h",
                     sent_a, bus_a.o_data, pkt(3'd5, 3'd3, 16'd1));
        end
        tick;
        tick;
        tests++;
        if (sent_a !== 16'd1 || bus_a.o_data_valid !== 1'b1 ||
            bus_a.o_data !== pkt(3'd5, 3'd3, 16'd1)) begin
            fails++;
            $display("FAIL bp_once: s=%0d v=%b d=%h, want 1 1 %h", sent_a,
                     bus_a.o_data_valid, bus_a.o_data, pkt(3'd5, 3'd3, 16'd1));
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] first_dest [3];
        first_dest = '{3'd2, 3'd5, 3'd4};
        bus_a.i_data_ready = 1'b1;
        do_reset;
        tick;
        tick;
        for (int i = 0; i < 100; i++) begin
            tests++;
            if (bus_a.o_data_valid !== 1'b1 || sent_a !== 16'(i) ||
                bus_a.o_data[15:0] !== 16'(i) ||
                bus_a.o_data[31:16] !== {3'd3, 13'd0} ||
                bus_a.o_data[34:32] === 3'd3) begin
                fails++;
                $display("FAIL b2b[%0d]: v=%b s=%0d d=%h, want seq %0d src 3 dest!=3",
                         i, bus_a.o_data_valid, sent_a, bus_a.o_data, i);
            end
            if (i < 3) begin
                tests++;
                if (bus_a.o_data[34:32] !== first_dest[i]) begin
                    fails++;
                    $display("FAIL b2b_dest[%0d]: got %0d want %0d",
                             i, bus_a.o_data[34:32], first_dest[i]);
                end
            end
            tick;
        end
        tests++;
        if (bus_a.o_data_valid !== 1'b0 || sent_a !== 16'd100 || txd_a !== 1'b1) begin
            fails++;
            $display("FAIL b2b_end: v=%b s=%0d t=%b, want 0 100 1",
                     bus_a.o_data_valid, sent_a, txd_a);
        end
        tick;
        tick;
        tests++;
        if (bus_a.o_data_valid !== 1'b0 || sent_a !== 16'd100 || txd_a !== 1'b1) begin
            fails++;
            $display("FAIL b2b_term: v=%b s=%0d t=%b, want 0 100 1",
                     bus_a.o_data_valid, sent_a, txd_a);
        end
    endtask

    task automatic test_gap;
        int w;
        bus_b.i_data_ready = 1'b1;
        do_reset;
        w = 0;
        while (bus_b.o_data_valid !== 1'b1 && w < 10) begin
            tick;
            w++;
        end
        tests++;
        if (bus_b.o_data_valid !== 1'b1 || w != 2) begin
            fails++;
            $display("FAIL gap_first: valid=%b after %0d edges, want 1 after 2",
                     bus_b.o_data_valid, w);
        end
        tests++;
        if (bus_b.o_data !== pkt(3'd4, 3'd5, 16'd0)) begin
            fails++;
            $display("FAIL gap_pkt0: got %h want %h",
                     bus_b.o_data, pkt(3'd4, 3'd5, 16'd0));
        end
        for (int k = 0; k < 28; k++) begin
            tests++;
            if (bus_b.o_data_valid !== (k % 3 == 0)) begin
                fails++;
                $display("FAIL gap_pat[%0d]: valid=%b want %b",
                         k, bus_b.o_data_valid, (k % 3 == 0));
            end
            tick;
        end
        tests++;
        if (bus_b.o_data_valid !== 1'b0 || sent_b !== 16'd10 || txd_b !== 1'b1) begin
            fails++;
            $display("FAIL gap_end: v=%b s=%0d t=%b, want 0 10 1",
                     bus_b.o_data_valid, sent_b, txd_b);
        end
    endtask

    task automatic test_rx;
        bus_a.i_data_ready = 1'b0;
        do_reset;
        tick;
        for (int i = 0; i < 20; i++) begin
            bus_a.i_data = pkt(3'd3, 3'd1, 16'(i));
            bus_a.i_data_valid = 1'b1;
            tick;
        end
        bus_a.i_data_valid = 1'b0;
        tests++;
        if (rcvd_a !== 16'd20 || err_a !== 1'b0) begin
            fails++;
            $display("FAIL rx_good: rcvd=%0d err=%b, want 20 0", rcvd_a, err_a);
        end
        bus_a.i_data = pkt(3'd2, 3'd1, 16'd20);
        bus_a.i_data_valid = 1'b1;
        tick;
        bus_a.i_data_valid = 1'b0;
        tests++;
        if (rcvd_a !== 16'd21 || err_a !== 1'b1) begin
            fails++;
            $display("FAIL rx_bad: rcvd=%0d err=%b, want 21 1", rcvd_a, err_a);
        end
        tick;
        tick;
        tick;
        tests++;
        if (rcvd_a !== 16'd21 || err_a !== 1'b1) begin
            fails++;
            $display("FAIL rx_sticky: rcvd=%0d err=%b, want 21 1", rcvd_a, err_a);
        end
        bus_a.i_data = pkt(3'd3, 3'd1, 16'd21);
        bus_a.i_data_valid = 1'b1;
        bus_a.i_data_ready = 1'b1;
        tick;
        bus_a.i_data_valid = 1'b0;
        bus_a.i_data_ready = 1'b0;
        tests++;
        if (rcvd_a !== 16'd22 || sent_a !== 16'd1) begin
            fails++;
            $display("FAIL rx_tx_same: rcvd=%0d sent=%0d, want 22 1", rcvd_a, sent_a);
        end
    endtask

    task automatic test_done;
        int w;
        bus_a.i_data_ready = 1'b1;
        do_reset;
        w = 0;
        while (sent_a !== 16'd40 && w < 200) begin
            tick;
            w++;
        end
        tests++;
        if (sent_a !== 16'd40 || bus_a.o_data_valid !== 1'b1) begin
            fails++;
            $display("FAIL done_wait: sent=%0d valid=%b, want 40 1",
                     sent_a, bus_a.o_data_valid);
        end
        done_a = 1'b1;
        tick;
        tests++;
        if (sent_a !== 16'd41 || bus_a.o_data_valid !== 1'b0 || txd_a !== 1'b1) begin
            fails++;
            $display("FAIL done_stop: s=%0d v=%b t=%b, want 41 0 1",
                     sent_a, bus_a.o_data_valid, txd_a);
        end
        done_a = 1'b0;
        tick;
        tick;
        tick;
        tests++;
        if (sent_a !== 16'd41 || bus_a.o_data_valid !== 1'b0 || txd_a !== 1'b1) begin
            fails++;
            $display("FAIL done_hold: s=%0d v=%b t=%b, want 41 0 1",
                     sent_a, bus_a.o_data_valid, txd_a);
        end
        for (int i = 0; i < 3; i++) begin
            bus_a.i_data = pkt(3'd3, 3'd0, 16'(i));
            bus_a.i_data_valid = 1'b1;
            tick;
        end
        bus_a.i_data_valid = 1'b0;
        tests++;
        if (rcvd_a !== 16'd3 || bus_a.o_data_ready !== 1'b1) begin
            fails++;
            $display("FAIL done_rx: rcvd=%0d rdy=%b, want 3 1",
                     rcvd_a, bus_a.o_data_ready);
        end
    endtask

    task automatic test_reset_mid_send;
        bus_a.i_data_ready = 1'b1;
        do_reset;
        tick;
        tick;
        tick;
        tick;
        tick;
        bus_a.i_data_ready = 1'b0;
        tests++;
        if (sent_a !== 16'd3 || bus_a.o_data_valid !== 1'b1 ||
            bus_a.o_data[15:0] !== 16'd3) begin
            fails++;
            $display("FAIL mid_pre: s=%0d v=%b d=%h, want 3 1 seq 3",
                     sent_a, bus_a.o_data_valid, bus_a.o_data);
        end
        bus_a.i_data = pkt(3'd6, 3'd0, 16'd0);
        bus_a.i_data_valid = 1'b1;
        tick;
        bus_a.i_data_valid = 1'b0;
        rst = 1'b1;
        tick;
        tests++;
        if (bus_a.o_data_valid !== 1'b0 || bus_a.o_data !== 35'd0 ||
            bus_a.o_data_ready !== 1'b0 || sent_a !== 16'd0 ||
            rcvd_a !== 16'd0 || err_a !== 1'b0 || txd_a !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst: v=%b d=%h r=%b s=%0d c=%0d e=%b t=%b",
                     bus_a.o_data_valid, bus_a.o_data, bus_a.o_data_ready,
                     sent_a, rcvd_a, err_a, txd_a);
        end
        rst = 1'b0;
        tick;
        tick;
        tests++;
        if (bus_a.o_data_valid !== 1'b1 || bus_a.o_data !== pkt(3'd2, 3'd3, 16'd0)) begin
            fails++;
            $display("FAIL mid_restart: v=%b d=%h, want 1 %h",
                     bus_a.o_data_valid, bus_a.o_data, pkt(3'd2, 3'd3, 16'd0));
        end
        bus_a.i_data_ready = 1'b1;
        tick;
        tests++;
        if (bus_a.o_data !== pkt(3'd5, 3'd3, 16'd1) || sent_a !== 16'd1) begin
            fails++;
            $display("FAIL mid_second: d=%h s=%0d, want %h 1",
                     bus_a.o_data, sent_a, pkt(3'd5, 3'd3, 16'd1));
        end
    endtask

    initial begin
        done_a = 1'b0;
        done_b = 1'b0;
        bus_a.i_data_ready = 1'b0;
        bus_a.i_data       = '0;
        bus_a.i_data_valid = 1'b0;
        bus_b.i_data_ready = 1'b1;
        bus_b.i_data       = '0;
        bus_b.i_data_valid = 1'b0;
        test_reset;
        test_backpressure;
        test_back_to_back;
        test_gap;
        test_rx;
        test_done;
        test_reset_mid_send;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
